mem_req_ctrl: RTL
=================

# mem_req_ctrl

Request front-end for the single-port synchronous `mem` block (DATA_WIDTH 32, ADDR_WIDTH 8). It accepts read/write commands over a valid/ready interface and buffers them in a small in-order command FIFO. It sequences them onto `mem`'s `rd`/`wr`/`addr`/`wdata` strobes, one access at a time. Read data captured from `mem` is returned over a valid/ready response port with backpressure.

## Interface
- DATA_WIDTH, 32, data word width; matches `mem`.
- ADDR_WIDTH, 8, address width; matches `mem` (256 locations).
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  FIFO can accept; high when FIFO not full and rst low.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  command address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_WIDTH  read data; stable while rsp_valid high.
- mem_rd  out  1  to `mem.rd`; one-cycle pulse.
- mem_wr  out  1  to `mem.wr`; one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  to `mem.addr`.
- mem_wdata  out  DATA_WIDTH  to `mem.wdata`.
- mem_rdata  in  DATA_WIDTH  from `mem.rdata`; valid the cycle after the edge that sampled mem_rd.
- cmd_count  out  $clog2(CMD_DEPTH)+1  current FIFO occupancy.

## Operation
- Command FIFO, CMD_DEPTH deep, stores {wr, addr, wdata}.
  - Push on req_valid & req_ready.
  - Pop only in IDLE when non-empty.
- Push and pop in the same edge: count unchanged.
- When full, req_ready is low; no push is possible, including in a pop edge (ready is derived from registered count).
- Push into an empty FIFO is not visible to the FSM until the next edge.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
  - IDLE: if count>0, pop head. Register mem_addr and mem_wdata from it. Set mem_wr=wr, mem_rd=~wr. Go to ACCESS. Otherwise stay in IDLE with strobes low.
  - ACCESS: strobe is high this cycle and `mem` samples it at the closing edge. At that edge, clear mem_rd/mem_wr. Next state is IDLE for a write, CAPTURE for a read.
  - CAPTURE: latch mem_rdata into rsp_rdata, set rsp_valid, go to RESP.
  - RESP: hold rsp_valid/rsp_rdata. On the rsp_valid & rsp_ready edge, clear rsp_valid and go to IDLE.
- Strictly in-order; one access outstanding. A read after a write to the same address returns the written data.
- mem_addr/mem_wdata hold their last value outside ACCESS; only the strobes qualify them.
- Addresses are used verbatim. 0xFF and 0x00 are ordinary locations; no wrap logic.
- mem_rd and mem_wr are never high together.

## Timing
- Reset (async, immediate on rst rise):
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0.
  - FIFO empty, cmd_count=0, state IDLE.
  - req_ready=0 while rst high, 1 from the first cycle after release.
- Reset mid-operation:
  - Queued commands are dropped and any in-flight strobe is cut.
  - A pending response is discarded; rsp_valid drops immediately.
- Write latency, empty FIFO, command accepted at edge E0:
  - Pop at E1; mem_wr high between E1 and E2.
  - `mem` writes at E2; next pop possible at E3.
  - Sustained write rate: 1 per 2 cycles.
- Read latency, accepted at E0:
  - mem_rd high E1–E2; mem_rdata valid after E2.
  - Latched at E3; rsp_valid high from E3.
  - If rsp_ready is held high, handshake at E4; next pop at E5.
- Backpressure:
  - rsp_ready low holds RESP indefinitely; FIFO keeps accepting until full.
  - rsp_ready may be high before rsp_valid; it has no effect outside RESP.

## Test plan
- Reset, then write 0xCAFEBABE @0x0A, then read @0x0A:
  - mem_wr pulse with addr 0x0A 2 edges after accept.
  - rsp_valid 3 edges after read accept, rsp_rdata=0xCAFEBABE.
- Push 5 writes back-to-back (data 0x1..0x5, addrs 0x10..0x14):
  - req_ready low once cmd_count=4; 5th accepted only after first pop.
  - All 5 mem_wr pulses in order, 2 cycles apart.
- Write 0x0ABCDEFE @0x15 then read @0x15 with rsp_ready low 5 cycles:
  - rsp_valid and rsp_rdata=0x0ABCDEFE held stable the whole time.
  - Single handshake on release; no extra mem_rd.
- Write 0xDEADBEEF @0xFF, write 0x12345678 @0x00, read @0xFF, read @0x00:
  - Responses 0xDEADBEEF then 0x12345678, in order.
- Assert rst during ACCESS of a read with 2 queued commands:
  - Strobes and rsp_valid drop immediately; cmd_count=0.
  - No response after release; req_ready=1 the cycle after release.
- Random mixed stream (≥200 commands) against a 256-entry reference model:
  - Every response matches the model.
  - mem_rd & mem_wr never both high.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//
// Request front-end for the single-port synchronous `mem` block. Commands
// (read or write) arrive over a valid/ready port and are buffered in a small
// in-order FIFO. A four-state sequencer pops one command at a time and drives
// mem's rd/wr/addr/wdata strobes. Read data from mem is returned over a
// valid/ready response port that supports backpressure.
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   command present
//   req_ready  out  FIFO can accept (not full, not in reset)
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   command address
//   req_wdata  in   write data (ignored for reads)
//   rsp_valid  out  read data available
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  read data, stable while rsp_valid is high
//   mem_rd     out  read strobe to mem (one-cycle pulse)
//   mem_wr     out  write strobe to mem (one-cycle pulse)
//   mem_addr   out  address to mem
//   mem_wdata  out  write data to mem
//   mem_rdata  in   read data from mem, valid the cycle after mem_rd is sampled
//   cmd_count  out  current FIFO occupancy
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [$clog2(CMD_DEPTH):0]    cmd_count
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command FIFO storage
    logic [CMD_DEPTH-1:0]  fifo_wr;
    logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    // Next values of the registered outputs
    logic                  mem_rd_nxt;
    logic                  mem_wr_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    assign fifo_full  = (count == CNT_W'(CMD_DEPTH));
    assign fifo_empty = (count == '0);

    // Ready comes from the registered count only, so a pop in the same edge
    // never frees a slot for a simultaneous push.
    assign req_ready = ~rst & ~fifo_full;
    assign push      = req_valid & req_ready;

    // The FSM only sees the registered count, so a command pushed into an
    // empty FIFO is popped at the following edge at the earliest.
    assign pop       = (state == ST_IDLE) & ~fifo_empty;

    assign cmd_count = count;

    // FIFO payload storage; needs no reset because occupancy is tracked by
    // count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]    <= req_wr;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    // Next-state and output logic. Strobes default low so they are exactly
    // one cycle wide; address/data default to holding their last value.
    always_comb begin
        state_nxt     = state;
        mem_rd_nxt    = 1'b0;
        mem_wr_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            ST_IDLE: begin
                if (pop) begin
                    mem_addr_nxt  = fifo_addr[rd_ptr];
                    mem_wdata_nxt = fifo_wdata[rd_ptr];
                    mem_wr_nxt    = fifo_wr[rd_ptr];
                    mem_rd_nxt    = ~fifo_wr[rd_ptr];
                    state_nxt     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // mem samples the strobe at the closing edge of this cycle;
                // reads then wait one cycle for mem_rdata to become valid.
                state_nxt = mem_rd ? ST_CAPTURE : ST_IDLE;
            end

            ST_CAPTURE: begin
                rsp_rdata_nxt = mem_rdata;
                rsp_valid_nxt = 1'b1;
                state_nxt     = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
